// File: rtl/video_pkg.sv
// Shared video constants and types for the pixel path.
// PIXEL_PACKED24_EN selects packed 24bpp (PB=24); otherwise RGBX 32bpp (PB=32).
package video_pkg;

    localparam int unsigned PIXFIFO_W = 64;
    localparam int unsigned RGB_W     = 24;
    localparam int unsigned ACC_W     = 128;
    localparam int unsigned LVL_W     = 8;

`ifdef PIXEL_PACKED24_EN
    localparam int unsigned PB = 24;
`else
    localparam int unsigned PB = 32;
`endif

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/pixel_word_unpacker.sv
// Unpacks 64-bit FIFO words into one RGB pixel per accepted cycle, with underflow tracking.
// Pixel format chosen at compile time by PIXEL_PACKED24_EN (see video_pkg).
module pixel_word_unpacker
    import video_pkg::*;
#(
    parameter logic [RGB_W-1:0] UNDERFLOW_RGB = 24'hFF00FF,
    parameter int unsigned      CNT_W         = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 pixfifo_empty_i,
    output logic                 pixfifo_req_o,
    input  logic [PIXFIFO_W-1:0] pixfifo_word_i,
    input  logic                 pix_ready_i,
    output logic                 pix_valid_o,
    output logic [RGB_W-1:0]     pix_o,
    output logic                 underflow_o,
    output logic [CNT_W-1:0]     underflow_cnt_o
);

    localparam logic [LVL_W-1:0] PbLvl   = LVL_W'(PB);
    localparam logic [LVL_W:0]   WordLvl = (LVL_W + 1)'(PIXFIFO_W);

    logic [ACC_W-1:0] acc_q, acc_d, acc_shift;
    logic [LVL_W-1:0] lvl_q, lvl_d, lvl_c;
    logic             infl_q, infl_d;
    logic             uf_q, uf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             consume, underflow;
    logic [LVL_W:0]   occupancy;
    rgb_t             px;

    always_comb begin
        occupancy     = {1'b0, lvl_q} + (infl_q ? WordLvl : '0);
        pixfifo_req_o = !rst_i && !pixfifo_empty_i && !flush_i && (occupancy <= WordLvl);
        pix_valid_o   = (lvl_q >= PbLvl);
        px            = acc_q[RGB_W-1:0];
        pix_o         = pix_valid_o ? px : UNDERFLOW_RGB;
        underflow_o     = uf_q;
        underflow_cnt_o = cnt_q;
    end

    always_comb begin
        consume   = pix_ready_i && pix_valid_o;
        underflow = pix_ready_i && !pix_valid_o;
        acc_shift = consume ? (acc_q >> PB) : acc_q;
        lvl_c     = consume ? (lvl_q - PbLvl) : lvl_q;

        acc_d  = acc_shift;
        lvl_d  = lvl_c;
        infl_d = pixfifo_req_o;
        uf_d   = uf_q;
        cnt_d  = cnt_q;

        // Bits above lvl are kept zero, so the incoming word can simply be OR-ed in.
        if (infl_q) begin
            acc_d = acc_shift | ({{(ACC_W - PIXFIFO_W){1'b0}}, pixfifo_word_i} << lvl_c);
            lvl_d = lvl_c + LVL_W'(PIXFIFO_W);
        end

        if (underflow) begin
            uf_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (flush_i) begin
            acc_d  = '0;
            lvl_d  = '0;
            infl_d = 1'b0;
            uf_d   = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            lvl_q  <= '0;
            infl_q <= 1'b0;
            uf_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            lvl_q  <= lvl_d;
            infl_q <= infl_d;
            uf_q   <= uf_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: doc/pixel_word_unpacker.md
# pixel_word_unpacker

- Converts 64-bit pixel words from the SDRAM-reader pixel FIFO into one 24-bit RGB pixel per accepted cycle for the HDMI timing/pixel stage.
- Sits in the 165 MHz pixel clock domain, between the FIFO read side (`pixfifo_word`/`pixfifo_req`) and the video timing generator.
- Prefetches words into a bit accumulator, unpacks the fixed pixel format, and flags and counts underflows.

## Interface
Parameters:
- `UNDERFLOW_RGB`, default 24'hFF00FF: colour driven on `pix_o` whenever `pix_valid_o`=0.
- `CNT_W`, default 16: width of the underflow counter (saturating).

Ports:
- `clk_i` in 1: pixel clock. One clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous flush at start of frame.
- `pixfifo_empty_i` in 1: upstream FIFO empty.
- `pixfifo_req_o` out 1: FIFO read request. Data appears on `pixfifo_word_i` exactly 1 cycle later.
- `pixfifo_word_i` in 64: FIFO read data.
- `pix_ready_i` in 1: downstream consumes a pixel this cycle (DE active).
- `pix_valid_o` out 1: `pix_o` holds a real pixel.
- `pix_o` out 24: RGB pixel, {R[23:16], G[15:8], B[7:0]}.
- `underflow_o` out 1: sticky; set on any underflow, cleared only by `rst_i` or `flush_i`.
- `underflow_cnt_o` out CNT_W: number of underflow cycles, saturating at all-ones.

## Operation
- State: 128-bit accumulator `acc`, bit level `lvl` (0..128), in-flight flag `infl`.
- Pixel format bits per pixel, `PB`:
  - `PB`=32 in default mode: pixel k of a word is bits [32k+23:32k]; bits [32k+31:32k+24] are ignored.
  - `PB`=24 in packed mode: little-endian bitstream; pixel 0 occupies bits [23:0] of the first word.
- Request rule: `pixfifo_req_o` = !`pixfifo_empty_i` && !`flush_i` && (`lvl` + 64·`infl` ≤ 64). This is evaluated on registered `lvl`/`infl`, ignoring same-cycle consumption. `infl` ← `pixfifo_req_o`.
- Output:
  - `pix_valid_o` = (`lvl` ≥ `PB`).
  - `pix_o` = `acc[23:0]` when valid, else `UNDERFLOW_RGB`.
  - Both are driven from registers and combinational logic only; no input-to-output path except through `pix_valid_o` gating.
- Consume: if `pix_ready_i` && `pix_valid_o`, then `acc` >>= `PB` and `lvl` −= `PB`.
- Append: if `infl`, the word is written at bit offset (`lvl` − consumed) and `lvl` += 64. Consume and append happen in the same cycle when both apply.
- Underflow: `pix_ready_i` && !`pix_valid_o` sets `underflow_o` and increments `underflow_cnt_o` (saturating). The pixel is not owed later; the stream is not shifted.
- Flush: `flush_i` forces `lvl` ← 0 and `infl` ← 0. A word arriving in the flush cycle is discarded. `underflow_o` and `underflow_cnt_o` are cleared. `flush_i` has priority over consume, append and underflow in the same cycle.
- Residual bits left at `lvl` < `PB` are held until more data arrives or a flush occurs.

## Timing
- Reset values: `pixfifo_req_o`=0, `pix_valid_o`=0, `pix_o`=`UNDERFLOW_RGB`, `underflow_o`=0, `underflow_cnt_o`=0, `lvl`=0, `infl`=0.
- Prefill latency: with FIFO non-empty, `pix_valid_o` rises 2 cycles after the first cycle with !`rst_i` && !`flush_i` (request at cycle 0, data at cycle 1, valid at cycle 2).
- Throughput: with FIFO never empty, the block sustains `pix_ready_i` held high indefinitely with zero underflows in both modes.
  - 32bpp: one request every 2 cycles.
  - Packed 24bpp: 3 requests per 8 pixels.
- Reset mid-line: all state is lost immediately. The in-flight word is dropped; the FIFO read side is not informed.

## Configuration
- `PIXEL_PACKED24_EN` defined: `PB`=24, packed 24bpp bitstream (8 pixels per 3 words).
- `PIXEL_PACKED24_EN` undefined: `PB`=32, RGBX 32bpp (2 pixels per word).
- The host software frame layout in SDRAM must match the compiled mode.

## Structure
- Shared package `video_pkg`: `PIXFIFO_W`=64, `RGB_W`=24, `ACC_W`=128, the `PB` localparam selected by `PIXEL_PACKED24_EN`, and the RGB typedef {r,g,b}.
- Single module; no sub-module. The accumulator shift/insert is combinational logic inside the module.

## Test plan
- Reset release, FIFO non-empty, 32bpp, words 64'h00AABBCC_00112233, …: `pix_valid_o` at cycle 2, `pix_o` = 24'h112233 then 24'hAABBCC, continuous.
- Packed mode, words 64'h..., `pix_ready_i` held high for 800 cycles with FIFO always non-empty: 800 pixels in correct bitstream order; `underflow_cnt_o`=0; exactly 300 requests.
- FIFO empty while `pix_ready_i` is high for 5 cycles: `pix_o`=24'hFF00FF, `underflow_o`=1, `underflow_cnt_o`=5; output resumes with the next correct pixel, none skipped.
- `flush_i` asserted in the same cycle as an arriving word: the word is discarded, `lvl`=0, `underflow_o` cleared, `pix_valid_o`=0 next cycle; the next word supplies pixel 0.
- Underflow held for 2^CNT_W + 10 cycles: the counter saturates at all-ones and does not wrap.
- `rst_i` asserted asynchronously mid-line with a request in flight: all outputs take their reset values immediately; the stale word returned after reset is ignored (`infl`=0).
